// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver and transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_e;

    // Clocks per oversample tick, integer floor.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on wrap; clr holds phase at 0.
module uart_baud_tick #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: self-timed oversampling, majority vote, valid/ready output with error flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned OSW = $clog2(OVERSAMPLE);
    localparam int unsigned BCW = $clog2(DATA_BITS + 1);
    localparam parity_e     PAR_MODE = parity_e'(PARITY[1:0]);

    if (DIV < 2) begin : g_bad_div
        $error("uart_rx_param: CLK_HZ/(BAUD*OVERSAMPLE) must be >= 2");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_fmt
        $error("uart_rx_param: unsupported frame format");
    end

    rx_state_e            state_q, state_d;
    logic                 rx_meta_q, rs_q;
    logic [OSW-1:0]       os_q, os_d, os_inc;
    logic [BCW-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [1:0]           smp_q, smp_d;
    logic                 par_q, par_d;
    logic                 fe_acc_q, fe_acc_d;
    logic                 stp_q, stp_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;

    logic tick, tick_clr, wrap, s_a, s_b, s_dec, vote, last_stop, par_calc, par_fail;
    logic frame_done;

    // Tick phase is re-aligned to each start edge by holding the divider in IDLE.
    assign tick_clr = (state_q == ST_IDLE);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    assign os_inc    = (os_q == OSW'(OVERSAMPLE - 1)) ? '0 : os_q + OSW'(1);
    assign wrap      = tick && (os_q == OSW'(OVERSAMPLE - 1));
    assign s_a       = tick && (os_inc == OSW'(OVERSAMPLE / 2 - 1));
    assign s_b       = tick && (os_inc == OSW'(OVERSAMPLE / 2));
    assign s_dec     = tick && (os_inc == OSW'(OVERSAMPLE / 2 + 1));
    assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rs_q) | (smp_q[1] & rs_q);
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stp_q;
    assign par_calc  = ^{shreg_q, par_q};
    assign par_fail  = (PAR_MODE == PAR_ODD)  ? ~par_calc :
                       (PAR_MODE == PAR_EVEN) ?  par_calc : 1'b0;

    always_comb begin
        state_d    = state_q;
        os_d       = os_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        smp_d      = smp_q;
        par_d      = par_q;
        fe_acc_d   = fe_acc_q;
        stp_d      = stp_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = 1'b0;
        frame_done = 1'b0;

        if (tick) os_d = os_inc;
        if (s_a)  smp_d[0] = rs_q;
        if (s_b)  smp_d[1] = rs_q;

        case (state_q)
            ST_IDLE: begin
                os_d = '0;
                if (!rs_q) begin
                    state_d  = ST_START;
                    bit_d    = '0;
                    stp_d    = 1'b0;
                    fe_acc_d = 1'b0;
                end
            end
            ST_START: begin
                if (s_b && rs_q) state_d = ST_IDLE;
                if (wrap)        state_d = ST_DATA;
            end
            ST_DATA: begin
                if (s_dec) begin
                    shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BCW'(1);
                end
                if (wrap && (bit_q == BCW'(DATA_BITS)))
                    state_d = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: begin
                if (s_dec) par_d = vote;
                if (wrap)  state_d = ST_STOP;
            end
            ST_STOP: begin
                if (s_dec) begin
                    if (!vote) fe_acc_d = 1'b1;
                    // Completion at the mid-point of the last stop bit; a zero word with a low stop is a break.
                    if (last_stop) begin
                        frame_done = 1'b1;
                        state_d    = ((shreg_q == '0) && !vote) ? ST_BREAK_WAIT : ST_IDLE;
                    end
                end
                if (wrap) stp_d = 1'b1;
            end
            ST_BREAK_WAIT: begin
                if (rs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shreg_q;
                perr_d     = par_fail;
                ferr_d     = fe_acc_q | ~vote;
                rx_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rs_q       <= 1'b1;
            state_q    <= ST_IDLE;
            os_q       <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            smp_q      <= '0;
            par_q      <= 1'b0;
            fe_acc_q   <= 1'b0;
            stp_q      <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rs_q       <= rx_meta_q;
            state_q    <= state_d;
            os_q       <= os_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            smp_q      <= smp_d;
            par_q      <= par_d;
            fe_acc_q   <= fe_acc_d;
            stp_q      <= stp_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8N1 and 8E2 instances driven with directed and random frames.
module tb_uart_rx_param;

    localparam int BIT_CLK = 160;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rx0, rx1, rdy0, rdy1;
    logic [7:0] d0, d1;
    logic       v0, pe0, fe0, ov0, bz0;
    logic       v1, pe1, fe1, ov1, bz1;

    int    errors = 0;
    int    checks = 0;
    int    ovr0 = 0;
    int    gap0 = 0;
    int    last_gap0 = 0;
    word_t q0[$];
    word_t q1[$];

    uart_rx_param #(.CLK_HZ(1600000), .BAUD(10000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
        .parity_err(pe0), .frame_err(fe0), .overrun_err(ov0), .busy(bz0));

    uart_rx_param #(.CLK_HZ(1600000), .BAUD(10000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
        .parity_err(pe1), .frame_err(fe1), .overrun_err(ov1), .busy(bz1));

    // Collect accepted words, overrun pulses and idle gaps between busy periods.
    always @(negedge clk) begin
        if (v0 && rdy0) q0.push_back({d0, pe0, fe0});
        if (v1 && rdy1) q1.push_back({d1, pe1, fe1});
        if (ov0) ovr0 <= ovr0 + 1;
        if (bz0) begin
            if (gap0 != 0) last_gap0 <= gap0;
            gap0 <= 0;
        end else begin
            gap0 <= gap0 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input int ch, input logic b, input int n);
        if (ch == 0) rx0 = b;
        else         rx1 = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int ch, input logic [7:0] data, input bit has_par, input logic pbit,
                        input logic [1:0] stop_low, input int nstop, input int idle_bits);
        line(ch, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) line(ch, data[i], BIT_CLK);
        if (has_par) line(ch, pbit, BIT_CLK);
        for (int s = 0; s < nstop; s++) line(ch, ~stop_low[s], BIT_CLK);
        if (idle_bits > 0) line(ch, 1'b1, idle_bits * BIT_CLK);
    endtask

    // Expected word from the line-level frame rules.
    function automatic word_t model(input logic [7:0] data, input int par, input logic pbit,
                                    input logic [1:0] stop_low, input int nstop);
        word_t w;
        logic  x;
        x    = (^data) ^ pbit;
        w.d  = data;
        w.pe = (par == 1) ? (x != 1'b1) : (par == 2) ? (x != 1'b0) : 1'b0;
        w.fe = stop_low[0] | ((nstop == 2) && stop_low[1]);
        return w;
    endfunction

    task automatic expect_word(input int ch, input string tag, input word_t exp);
        word_t got;
        int    n;
        n = (ch == 0) ? q0.size() : q1.size();
        chk({tag, "_avail"}, 32'(n != 0), 32'd1);
        got = 'x;
        if (n != 0) got = (ch == 0) ? q0.pop_front() : q1.pop_front();
        chk({tag, "_data"}, 32'(got.d), 32'(exp.d));
        chk({tag, "_perr"}, 32'(got.pe), 32'(exp.pe));
        chk({tag, "_ferr"}, 32'(got.fe), 32'(exp.fe));
    endtask

    initial begin
        logic [7:0] data;
        logic       pbit;
        logic [1:0] sl;

        rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_dut0", 32'({d0, v0, pe0, fe0, ov0, bz0}), 32'd0);
        chk("reset_dut1", 32'({d1, v1, pe1, fe1, ov1, bz1}), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Back-to-back 8N1 frames
        send(0, 8'h55, 1'b0, 1'b0, 2'b00, 1, 0);
        send(0, 8'hA3, 1'b0, 1'b0, 2'b00, 1, 2);
        chk("b2b_count", 32'(q0.size()), 32'd2);
        expect_word(0, "b2b_55", model(8'h55, 0, 1'b0, 2'b00, 1));
        expect_word(0, "b2b_a3", model(8'hA3, 0, 1'b0, 2'b00, 1));
        chk("busy_gap_lt80", 32'((last_gap0 > 0) && (last_gap0 < 80)), 32'd1);

        // Even parity, two stop bits
        send(1, 8'hA3, 1'b1, 1'b0, 2'b00, 2, 1);
        expect_word(1, "even_ok", model(8'hA3, 2, 1'b0, 2'b00, 2));
        send(1, 8'hA3, 1'b1, 1'b1, 2'b00, 2, 1);
        expect_word(1, "even_bad", model(8'hA3, 2, 1'b1, 2'b00, 2));
        send(1, 8'h5A, 1'b1, 1'b0, 2'b10, 2, 1);
        expect_word(1, "stop2_low", model(8'h5A, 2, 1'b0, 2'b10, 2));

        // Low stop bit, then a long break
        send(0, 8'h3C, 1'b0, 1'b0, 2'b01, 1, 2);
        expect_word(0, "frame_err", model(8'h3C, 0, 1'b0, 2'b01, 1));
        line(0, 1'b0, 30 * BIT_CLK);
        chk("break_count", 32'(q0.size()), 32'd1);
        expect_word(0, "break", model(8'h00, 0, 1'b0, 2'b01, 1));
        chk("break_busy", 32'(bz0), 32'd1);
        line(0, 1'b1, 3 * BIT_CLK);
        chk("break_release_count", 32'(q0.size()), 32'd0);
        chk("break_release_busy", 32'(bz0), 32'd0);

        // Start-bit glitch
        line(0, 1'b0, 40);
        line(0, 1'b1, 2 * BIT_CLK);
        chk("glitch_count", 32'(q0.size()), 32'd0);
        chk("glitch_busy", 32'(bz0), 32'd0);

        // 0xFF with one low sample in bit 3 (edge sample) and bit 5 (centre sample)
        line(0, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                line(0, 1'b1, 54); line(0, 1'b0, 20); line(0, 1'b1, 86);
            end else if (i == 5) begin
                line(0, 1'b1, 76); line(0, 1'b0, 12); line(0, 1'b1, 72);
            end else begin
                line(0, 1'b1, BIT_CLK);
            end
        end
        line(0, 1'b1, 2 * BIT_CLK);
        expect_word(0, "vote_ff", model(8'hFF, 0, 1'b0, 2'b00, 1));

        // Overrun with consumer stalled
        rdy0 = 1'b0;
        send(0, 8'h11, 1'b0, 1'b0, 2'b00, 1, 1);
        send(0, 8'h22, 1'b0, 1'b0, 2'b00, 1, 2);
        chk("stall_valid", 32'(v0), 32'd1);
        chk("stall_data", 32'(d0), 32'h11);
        chk("overrun_pulses", 32'(ovr0), 32'd1);
        @(posedge clk);
        #2 rdy0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("accept_count", 32'(q0.size()), 32'd1);
        expect_word(0, "accept_11", model(8'h11, 0, 1'b0, 2'b00, 1));
        chk("accept_valid_clr", 32'(v0), 32'd0);
        send(0, 8'h33, 1'b0, 1'b0, 2'b00, 1, 1);
        expect_word(0, "after_33", model(8'h33, 0, 1'b0, 2'b00, 1));
        chk("overrun_total", 32'(ovr0), 32'd1);

        // Reset in the middle of bit 4 of 0x99
        line(0, 1'b0, BIT_CLK);
        line(0, 1'b1, BIT_CLK); line(0, 1'b0, BIT_CLK);
        line(0, 1'b0, BIT_CLK); line(0, 1'b1, BIT_CLK);
        line(0, 1'b1, 80);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midframe_reset", 32'({d0, v0, pe0, fe0, ov0, bz0}), 32'd0);
        rx0 = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        line(0, 1'b1, BIT_CLK);
        chk("post_reset_count", 32'(q0.size()), 32'd0);
        send(0, 8'h42, 1'b0, 1'b0, 2'b00, 1, 1);
        expect_word(0, "post_reset_42", model(8'h42, 0, 1'b0, 2'b00, 1));

        // Random frames on both instances
        for (int k = 0; k < 5; k++) begin
            data = 8'($urandom);
            pbit = (^data) ^ 1'($urandom_range(0, 1));
            sl   = 2'($urandom_range(0, 3));
            if (data == 8'h00) sl = 2'b00;
            send(1, data, 1'b1, pbit, sl, 2, 1);
            expect_word(1, "rand_8e2", model(data, 2, pbit, sl, 2));
        end
        for (int k = 0; k < 5; k++) begin
            data = 8'($urandom);
            sl   = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
            if (data == 8'h00) sl = 2'b00;
            send(0, data, 1'b0, 1'b0, sl, 1, 1);
            expect_word(0, "rand_8n1", model(data, 0, 1'b0, sl, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised asynchronous serial receiver. Next generation of the fixed 8N1 receiver.
- Generates its own oversampled bit timing, so no external baud-clock block or bps_start handshake is needed.
- Supports configurable data width, parity and stop-bit count, plus majority-vote sampling.
- Delivers each word through a valid/ready handshake with per-word error flags. Sits between the board RS232 pin and the command/data consumers.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line bit rate.
- OVERSAMPLE, 16: ticks per bit. Must be even and >= 8.
- DATA_BITS, 8: payload width, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  raw serial line, idle high, asynchronous to clk.
- rx_data  out  DATA_BITS  received word, LSB received first.
- rx_valid  out  1  word available. Held until accepted.
- rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready.
- parity_err  out  1  parity mismatch on the presented word. Qualified by rx_valid.
- frame_err  out  1  any stop bit sampled low on the presented word. Qualified by rx_valid.
- overrun_err  out  1  one-cycle pulse: a completed frame was dropped.
- busy  out  1  high from start-bit detection until return to IDLE.

Behaviour:
- Interface: one clock (clk), asynchronous active-low reset (rst_n). All state is reset asynchronously.
- Reset values: rx_data = 0; rx_valid, parity_err, frame_err, overrun_err and busy = 0; FSM = IDLE.
- Synchroniser: rx passes through 2 flops, both reset to 1 (idle). All logic uses the synchronised value rs.
- Tick generator: DIV = CLK_HZ / (BAUD*OVERSAMPLE), integer floor, must be >= 2 (elaboration check).
  - Counter runs 0..DIV-1 and pulses tick on wrap.
  - Counter is held at 0 in IDLE, so tick phase aligns to the start edge.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE -> START on rs = 0 (falling level after idle).
  - START: at tick count OVERSAMPLE/2, resample. If rs = 1, treat as a glitch and return to IDLE with no output. Otherwise restart the bit counter and go to DATA.
  - DATA: one bit per OVERSAMPLE ticks. Bit value = majority of samples at ticks OS/2-1, OS/2, OS/2+1. Shift in LSB first. After DATA_BITS bits go to PARITY if PARITY != 0, else STOP.
  - PARITY: sample one bit. Error if the XOR of data and parity bit is not 1 (odd) or not 0 (even).
  - STOP: sample STOP_BITS bits. Any low sample sets the frame error.
    - Frame completes at mid-point of the last stop bit, then returns to IDLE immediately; no wait for the bit end.
    - If data = 0 and the stop bit is low (break), go to BREAK_WAIT instead.
  - BREAK_WAIT: stay until rs = 1, then go to IDLE. A held break yields exactly one frame.
- Output register on frame completion:
  - If rx_valid = 0, or rx_valid && rx_ready in the same cycle: load rx_data, parity_err and frame_err, and set rx_valid = 1.
  - Else the new frame is discarded, overrun_err pulses 1 cycle, and the presented word and flags are unchanged.
  - rx_valid && rx_ready with no completion: rx_valid clears next cycle.
- Latency: rx_valid rises 1 clk after the mid-point sample of the last stop bit.
- Reset mid-frame: immediate return to IDLE with outputs cleared. The next start is detected only after rs is seen at 1 (synchroniser reset to 1 guarantees this).
- rx_data, parity_err and frame_err must not change while rx_valid && !rx_ready.

Decomposition:
- Package uart_pkg:
  - parity enum (PAR_NONE / PAR_ODD / PAR_EVEN).
  - FSM state typedef.
  - Function calc_div(clk_hz, baud, os).
  - Shared by the future parametrised transmitter.
- Sub-module uart_baud_tick: divisor counter with a clear input and tick output. Reused by the transmitter.

Test Plan (sim: CLK_HZ = 1600000, BAUD = 10000, OVERSAMPLE = 16, so DIV = 10 and 160 clk per bit; rx_ready = 1 unless stated):
- 8N1, send 0x55 then 0xA3 back-to-back -> two rx_valid pulses with rx_data 0x55 and 0xA3, no errors, busy low between frames for < 80 clk.
- PARITY = 2: send 0xA3 with parity bit 0 -> parity_err = 0. Resend with parity bit 1 -> parity_err = 1, rx_data = 0xA3.
- Stop bit driven low on 0x3C -> frame_err = 1, rx_data = 0x3C. Line held low for 30 bit times -> exactly one frame with data 0x00 and frame_err = 1, then nothing until rx returns high.
- Glitch rx low for 40 clk -> no rx_valid and no busy after the START check. A single 20-clk glitch inside bit 3 of 0xFF -> rx_data = 0xFF (majority vote).
- rx_ready = 0: send 0x11 then 0x22 -> rx_data stays 0x11, overrun_err pulses once at the second completion. Raise rx_ready -> rx_valid clears and the next frame 0x33 is received.
- Assert rst_n low in the middle of bit 4 of 0x99 -> all outputs 0. Release and send 0x42 -> 0x42 received cleanly.
